divisor_restaurador: RTL and testbench



---
 rtl/divisor_restaurador.sv | 116 +++++++++++
 tb/tb_divisor_restaurador.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/divisor_restaurador.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock. Divide-by-zero and quotients that do
// not fit in N bits are flagged as overflow without iterating.
module divisor_restaurador #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividendo,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   cociente,
    output logic [N-1:0]   resto,
    output logic           busy,
    output logic           done,
    output logic           overflow
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t         state, state_nx;
    logic [N+1:0]   a, m;
    logic [N-1:0]   q;
    logic [CW-1:0]  cnt;

    logic [2*N+1:0] aq_sh;
    logic [N+1:0]   a_sh, t, a_nx;
    logic [N-1:0]   q_nx;
    logic           err, last;

    // Upper dividend half must be below the divisor, otherwise the quotient
    // needs more than N bits (divisor==0 is also caught by this compare).
    assign err  = (divisor == '0) || (dividendo[2*N-1:N] >= divisor);
    assign last = (cnt == CW'(1));

    // One restoring step: shift {A,Q}, trial-subtract M, keep or restore.
    always_comb begin
        aq_sh = {a, q} << 1;
        a_sh  = aq_sh[2*N+1:N];
        t     = a_sh - m;
        q_nx  = aq_sh[N-1:0];
        if (t[N+1]) begin
            a_nx    = a_sh;
            q_nx[0] = 1'b0;
        end else begin
            a_nx    = t;
            q_nx[0] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = err ? FIN : ITER;
            ITER: begin
                busy = 1'b1;
                if (last) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a        <= '0;
            q        <= '0;
            m        <= '0;
            cnt      <= '0;
            cociente <= '0;
            resto    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (err) begin
                        overflow <= 1'b1;
                        cociente <= '1;
                        resto    <= '0;
                    end else begin
                        a        <= {2'b00, dividendo[2*N-1:N]};
                        q        <= dividendo[N-1:0];
                        m        <= {2'b00, divisor};
                        cnt      <= CW'(N);
                        overflow <= 1'b0;
                    end
                end
                ITER: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    cnt <= cnt - 1'b1;
                    // Capture the step's result, not the stale register value.
                    if (last) begin
                        cociente <= q_nx;
                        resto    <= a_nx[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_restaurador.sv
// Scoreboard bench for divisor_restaurador: expectations are queued when an
// operation is driven and checked when done pulses.
module tb_divisor_restaurador;
    localparam int N = 3;

    logic           clk = 0;
    logic           reset = 1;
    logic           start = 0;
    logic [2*N-1:0] dividendo = '0;
    logic [N-1:0]   divisor = '0;
    logic [N-1:0]   cociente, resto;
    logic           busy, done, overflow;

    typedef struct {
        int coc;
        int res;
        int ovf;
        int k;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    divisor_restaurador #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividendo(dividendo), .divisor(divisor),
        .cociente(cociente), .resto(resto),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int dd, input int dv, input int k);
        exp_t e;
        e.k = k;
        if (dv == 0 || (dd >> N) >= dv) begin
            e.ovf = 1; e.coc = (1 << N) - 1; e.res = 0;
        end else begin
            e.ovf = 0; e.coc = dd / dv; e.res = dd % dv;
        end
        return e;
    endfunction

    // Result checker: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q_exp.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("cociente", int'(cociente), e.coc);
                chk("resto", int'(resto), e.res);
                chk("overflow", int'(overflow), e.ovf);
                chk("latency", cyc, e.k + (e.ovf != 0 ? 0 : N));
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Wait until all queued results are seen, then one cycle for FIN->IDLE.
    task automatic wait_idle();
        for (int i = 0; i < 40 && q_exp.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (q_exp.size() != 0) begin
            chk("timeout", q_exp.size(), 0);
            q_exp.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input int dd, input int dv);
        exp_t e;
        @(negedge clk);
        dividendo = dd[2*N-1:0];
        divisor   = dv[N-1:0];
        start     = 1;
        e = model(dd, dv, cyc + 1);
        q_exp.push_back(e);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", int'(busy), e.ovf != 0 ? 0 : 1);
        wait_idle();
    endtask

    initial begin
        int k;
        #1;
        chk("rst_cociente", int'(cociente), 0);
        chk("rst_resto", int'(resto), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        repeat (2) @(negedge clk);
        reset = 0;

        // Directed cases
        run_op(45, 7);
        run_op(20, 3);
        run_op(49, 7);
        run_op(0, 5);
        run_op(6, 0);
        run_op(56, 7);
        run_op(55, 7);

        // Inputs change and start stays high during ITER
        @(negedge clk);
        dividendo = 45; divisor = 7; start = 1;
        k = cyc + 1;
        q_exp.push_back(model(45, 7, k));
        q_exp.push_back(model(20, 3, k + N + 2));
        @(negedge clk);
        dividendo = 20; divisor = 3;
        for (int i = 0; i < 20 && cyc < k + N + 2; i++) @(negedge clk);
        start = 0;
        wait_idle();

        // Asynchronous reset in the second ITER cycle
        @(negedge clk);
        dividendo = 45; divisor = 7; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #1 reset = 1;
        #1;
        chk("arst_cociente", int'(cociente), 0);
        chk("arst_resto", int'(resto), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        run_op(45, 7);

        // Exhaustive sweep
        for (int dd = 0; dd < (1 << (2*N)); dd++)
            for (int dv = 0; dv < (1 << N); dv++)
                run_op(dd, dv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
